// File: rtl/change_dispenser_pkg.sv
// change_dispenser_pkg: shared coin-return constants and FSM state encoding.
//   NUM_COINS      number of denominations (index 0 = smallest)
//   COIN_VAL0..2   denomination values
//   AMT_W          amount width, matches the machine total width
//   INV_W/INV_INIT inventory counter width and post-reset count
//   state_t        dispenser FSM states
package change_dispenser_pkg;
   localparam int NUM_COINS = 3;
   localparam int COIN_VAL0 = 100;
   localparam int COIN_VAL1 = 500;
   localparam int COIN_VAL2 = 1000;
   localparam int AMT_W     = 31;
   localparam int INV_W     = 8;
   localparam int INV_INIT  = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SELECT = 2'd1,
      EMIT   = 2'd2,
      DONE   = 2'd3
   } state_t;
endpackage

// File: rtl/coin_inventory.sv
// coin_inventory: per-denomination hopper counters, saturating on refill.
//   clk, reset_n  clock and synchronous active-low reset (counters -> INV_INIT)
//   refill        per-coin +1 request (already qualified by the refill strobe)
//   dec           one-hot -1 request from a completed eject handshake
//   count         flattened counts, coin k at [k*INV_W +: INV_W]
//   nonzero       per-coin count > 0 flags for the greedy selector
module coin_inventory #(
   parameter int NUM_COINS = change_dispenser_pkg::NUM_COINS,
   parameter int INV_W     = change_dispenser_pkg::INV_W,
   parameter int INV_INIT  = change_dispenser_pkg::INV_INIT
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [NUM_COINS-1:0]       refill,
   input  logic [NUM_COINS-1:0]       dec,
   output logic [NUM_COINS*INV_W-1:0] count,
   output logic [NUM_COINS-1:0]       nonzero
);
   for (genvar k = 0; k < NUM_COINS; k++) begin : g_cnt
      logic [INV_W-1:0] c;
      // simultaneous refill and dispense cancel, so only the lone-refill case saturates
      always_ff @(posedge clk)
         if (!reset_n)
            c <= INV_W'(INV_INIT);
         else if (refill[k] && !dec[k] && !(&c))
            c <= c + INV_W'(1);
         else if (dec[k] && !refill[k])
            c <= c - INV_W'(1);
      assign count[k*INV_W +: INV_W] = c;
      assign nonzero[k] = |c;
   end
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: turns a return amount into greedy one-coin-per-handshake hopper ejects.
//   clk, reset_n    clock and synchronous active-low reset
//   i_req_valid     return request present; o_req_ready high when idle
//   i_req_amount    amount to return, sampled on accept
//   o_coin_valid    eject command valid; i_coin_ready hopper accepts it
//   o_coin          one-hot denomination, 0 when not valid
//   o_done          one-cycle pulse when the request finishes
//   o_shortfall     undispensed remainder of the last request
//   i_refill_valid  refill strobe; i_refill_coin adds one to each set denomination
//   o_inv_count     flattened inventory, coin k at [k*INV_W +: INV_W]
module change_dispenser #(
   parameter int NUM_COINS = change_dispenser_pkg::NUM_COINS,
   parameter int COIN_VAL0 = change_dispenser_pkg::COIN_VAL0,
   parameter int COIN_VAL1 = change_dispenser_pkg::COIN_VAL1,
   parameter int COIN_VAL2 = change_dispenser_pkg::COIN_VAL2,
   parameter int AMT_W     = change_dispenser_pkg::AMT_W,
   parameter int INV_W     = change_dispenser_pkg::INV_W,
   parameter int INV_INIT  = change_dispenser_pkg::INV_INIT
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       i_req_valid,
   output logic                       o_req_ready,
   input  logic [AMT_W-1:0]           i_req_amount,
   output logic                       o_coin_valid,
   input  logic                       i_coin_ready,
   output logic [NUM_COINS-1:0]       o_coin,
   output logic                       o_done,
   output logic [AMT_W-1:0]           o_shortfall,
   input  logic                       i_refill_valid,
   input  logic [NUM_COINS-1:0]       i_refill_coin,
   output logic [NUM_COINS*INV_W-1:0] o_inv_count
);
   import change_dispenser_pkg::*;

   state_t               state, state_nx;
   logic [AMT_W-1:0]     remaining, remaining_nx, shortfall, shortfall_nx, sel_val;
   logic [NUM_COINS-1:0] sel, sel_nx, pick, dec, nonzero;
   logic [AMT_W-1:0]     coin_val [NUM_COINS];

   for (genvar k = 0; k < NUM_COINS; k++) begin : g_val
      assign coin_val[k] = AMT_W'(k == 0 ? COIN_VAL0 : k == 1 ? COIN_VAL1 : COIN_VAL2);
   end

   coin_inventory #(.NUM_COINS(NUM_COINS), .INV_W(INV_W), .INV_INIT(INV_INIT)) u_inv (
      .clk     (clk),
      .reset_n (reset_n),
      .refill  (i_refill_valid ? i_refill_coin : '0),
      .dec     (dec),
      .count   (o_inv_count),
      .nonzero (nonzero)
   );

   // upward scan: the last eligible denomination seen (the largest) wins
   always_comb begin
      pick    = '0;
      sel_val = '0;
      for (int k = 0; k < NUM_COINS; k++) begin
         if (coin_val[k] <= remaining && nonzero[k]) begin
            pick    = '0;
            pick[k] = 1'b1;
         end
         if (sel[k]) sel_val = coin_val[k];
      end
   end

   always_comb begin
      state_nx     = state;
      remaining_nx = remaining;
      sel_nx       = sel;
      shortfall_nx = shortfall;
      dec          = '0;
      o_req_ready  = 1'b0;
      o_coin_valid = 1'b0;
      o_coin       = '0;
      o_done       = 1'b0;
      case (state)
         IDLE: begin
            o_req_ready = 1'b1;
            if (i_req_valid) begin
               remaining_nx = i_req_amount;
               if (i_req_amount == '0) begin
                  shortfall_nx = '0;
                  state_nx     = DONE;
               end else
                  state_nx = SELECT;
            end
         end
         SELECT:
            if (|pick) begin
               sel_nx   = pick;
               state_nx = EMIT;
            end else begin
               shortfall_nx = remaining;
               state_nx     = DONE;
            end
         EMIT: begin
            // gated by reset_n so a reset cycle never presents an eject
            o_coin_valid = reset_n;
            o_coin       = reset_n ? sel : '0;
            if (i_coin_ready) begin
               dec          = sel;
               remaining_nx = remaining - sel_val;
               if (remaining_nx == '0) begin
                  shortfall_nx = '0;
                  state_nx     = DONE;
               end else
                  state_nx = SELECT;
            end
         end
         default: begin
            o_done   = reset_n;
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk)
      if (!reset_n) begin
         state     <= IDLE;
         remaining <= '0;
         sel       <= '0;
         shortfall <= '0;
      end else begin
         state     <= state_nx;
         remaining <= remaining_nx;
         sel       <= sel_nx;
         shortfall <= shortfall_nx;
      end

   assign o_shortfall = shortfall;
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed vector table plus hand sequences for three dispenser configurations.
module tb_change_dispenser;
   typedef struct packed {
      int          tgt;
      logic [30:0] amt;
      int          n;
      logic [11:0] coins;
      int          lat;
      logic [30:0] sf;
      logic [23:0] inv;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   int          tgt = 0;
   logic        req_valid = 1'b0;
   logic [30:0] req_amount = '0;
   logic        coin_ready = 1'b1;
   logic        refill_valid = 1'b0;
   logic [2:0]  refill_coin = '0;
   int          errors = 0;
   int          checks = 0;

   logic        a_req_ready, b_req_ready, c_req_ready;
   logic        a_coin_valid, b_coin_valid, c_coin_valid;
   logic [2:0]  a_coin, b_coin, c_coin;
   logic        a_done, b_done, c_done;
   logic [30:0] a_sf, b_sf, c_sf;
   logic [23:0] a_inv, b_inv;
   logic [8:0]  c_inv;

   logic        m_req_ready, m_coin_valid, m_done;
   logic [2:0]  m_coin;
   logic [30:0] m_sf;
   logic [23:0] m_inv;

   always #5 clk = ~clk;

   change_dispenser dut_a (
      .clk(clk), .reset_n(reset_n), .i_req_valid(req_valid && tgt == 0), .o_req_ready(a_req_ready),
      .i_req_amount(req_amount), .o_coin_valid(a_coin_valid), .i_coin_ready(coin_ready), .o_coin(a_coin),
      .o_done(a_done), .o_shortfall(a_sf), .i_refill_valid(refill_valid && tgt == 0),
      .i_refill_coin(refill_coin), .o_inv_count(a_inv));

   change_dispenser #(.INV_INIT(1)) dut_b (
      .clk(clk), .reset_n(reset_n), .i_req_valid(req_valid && tgt == 1), .o_req_ready(b_req_ready),
      .i_req_amount(req_amount), .o_coin_valid(b_coin_valid), .i_coin_ready(coin_ready), .o_coin(b_coin),
      .o_done(b_done), .o_shortfall(b_sf), .i_refill_valid(refill_valid && tgt == 1),
      .i_refill_coin(refill_coin), .o_inv_count(b_inv));

   change_dispenser #(.INV_W(3), .INV_INIT(7)) dut_c (
      .clk(clk), .reset_n(reset_n), .i_req_valid(req_valid && tgt == 2), .o_req_ready(c_req_ready),
      .i_req_amount(req_amount), .o_coin_valid(c_coin_valid), .i_coin_ready(coin_ready), .o_coin(c_coin),
      .o_done(c_done), .o_shortfall(c_sf), .i_refill_valid(refill_valid && tgt == 2),
      .i_refill_coin(refill_coin), .o_inv_count(c_inv));

   assign m_req_ready  = tgt == 1 ? b_req_ready  : tgt == 2 ? c_req_ready  : a_req_ready;
   assign m_coin_valid = tgt == 1 ? b_coin_valid : tgt == 2 ? c_coin_valid : a_coin_valid;
   assign m_coin       = tgt == 1 ? b_coin       : tgt == 2 ? c_coin       : a_coin;
   assign m_done       = tgt == 1 ? b_done       : tgt == 2 ? c_done       : a_done;
   assign m_sf         = tgt == 1 ? b_sf         : tgt == 2 ? c_sf         : a_sf;
   assign m_inv        = tgt == 1 ? b_inv        : tgt == 2 ? 24'(c_inv)   : a_inv;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // one request with the hopper always ready; counts cycles from accept to o_done
   task automatic run_vec(input vec_t v, input int idx);
      int          n = 0, lat = 0;
      logic [11:0] coins = '0;
      logic        zbad = 1'b0;
      tgt = v.tgt;
      coin_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("v%0d_ready", idx), m_req_ready, 1);
      req_valid = 1'b1;
      req_amount = v.amt;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int c = 1; c <= 200 && lat == 0; c++) begin
         @(negedge clk);
         if (!m_coin_valid && m_coin != 3'b000) zbad = 1'b1;
         if (m_coin_valid && coin_ready) begin
            if (n < 4) coins[3*n +: 3] = m_coin;
            n++;
         end
         if (m_done) lat = c;
      end
      chk($sformatf("v%0d_ncoins", idx), n, v.n);
      chk($sformatf("v%0d_coins", idx), coins, v.coins);
      chk($sformatf("v%0d_latency", idx), lat, v.lat);
      chk($sformatf("v%0d_shortfall", idx), m_sf, v.sf);
      chk($sformatf("v%0d_inv", idx), m_inv, v.inv);
      chk($sformatf("v%0d_coin_zero", idx), zbad, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[7];
      vec_t extra;
      logic bad;
      vecs[0] = '{0, 31'd1600, 3, 12'b000_001_010_100, 7, 31'd0,   {8'd7, 8'd7, 8'd7}};
      vecs[1] = '{0, 31'd150,  1, 12'b000_000_000_001, 4, 31'd50,  {8'd7, 8'd7, 8'd6}};
      vecs[2] = '{0, 31'd0,    0, 12'b000_000_000_000, 1, 31'd0,   {8'd7, 8'd7, 8'd6}};
      vecs[3] = '{0, 31'd2600, 4, 12'b001_010_100_100, 9, 31'd0,   {8'd5, 8'd6, 8'd5}};
      vecs[4] = '{0, 31'd350,  3, 12'b000_001_001_001, 8, 31'd50,  {8'd5, 8'd6, 8'd2}};
      vecs[5] = '{1, 31'd2100, 3, 12'b000_001_010_100, 8, 31'd500, 24'd0};
      vecs[6] = '{1, 31'd100,  0, 12'b000_000_000_000, 2, 31'd100, 24'd0};
      extra   = '{0, 31'd50,   0, 12'b000_000_000_000, 2, 31'd50,  {8'd5, 8'd6, 8'd3}};

      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", m_req_ready, 1);
      chk("rst_valid", m_coin_valid, 0);
      chk("rst_coin", m_coin, 0);
      chk("rst_done", m_done, 0);
      chk("rst_shortfall", m_sf, 0);
      chk("rst_inv", m_inv, {8'd8, 8'd8, 8'd8});

      for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

      // backpressure: three stalled cycles, then one handshake
      tgt = 0;
      coin_ready = 1'b0;
      @(negedge clk);
      req_valid = 1'b1;
      req_amount = 31'd500;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("bp_select_novalid", m_coin_valid, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("bp_stall%0d_valid", i), m_coin_valid, 1);
         chk($sformatf("bp_stall%0d_coin", i), m_coin, 3'b010);
      end
      @(posedge clk);
      #1 coin_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_coin", m_coin, 3'b010);
      @(negedge clk);
      chk("bp_done", m_done, 1);
      chk("bp_shortfall", m_sf, 0);
      chk("bp_inv", m_inv, {8'd5, 8'd5, 8'd2});
      @(negedge clk);
      chk("bp_done_pulse", m_done, 0);

      // refill of all denominations on the same edge as a coin-2 eject
      @(negedge clk);
      req_valid = 1'b1;
      req_amount = 31'd1000;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rf_coin", {m_coin_valid, m_coin}, 4'b1100);
      refill_valid = 1'b1;
      refill_coin = 3'b111;
      @(posedge clk);
      #1 refill_valid = 1'b0;
      @(negedge clk);
      chk("rf_done", m_done, 1);
      chk("rf_inv", m_inv, {8'd5, 8'd6, 8'd3});

      // saturation on the 3-bit inventory configuration
      tgt = 2;
      @(negedge clk);
      refill_valid = 1'b1;
      refill_coin = 3'b111;
      @(posedge clk);
      #1 refill_valid = 1'b0;
      @(negedge clk);
      chk("sat_inv", m_inv, 24'h1FF);

      run_vec(extra, 7);

      // reset one cycle after the first handshake of a multi-coin request
      tgt = 0;
      coin_ready = 1'b1;
      @(negedge clk);
      req_valid = 1'b1;
      req_amount = 31'd3000;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("mr_first_coin", {m_coin_valid, m_coin}, 4'b1100);
      @(posedge clk);
      #1 reset_n = 1'b0;
      @(negedge clk);
      chk("mr_no_done", m_done, 0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      chk("mr_ready", m_req_ready, 1);
      chk("mr_valid", m_coin_valid, 0);
      chk("mr_inv", m_inv, {8'd8, 8'd8, 8'd8});
      chk("mr_shortfall", m_sf, 0);
      bad = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (m_done || m_coin_valid) bad = 1'b1;
      end
      chk("mr_quiet", bad, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
